// File: rtl/regfile_sb.sv
// MIPS-style register file with HI/LO pair, write-first bypass on all read
// ports and a per-register pending-write scoreboard that raises RAW stalls.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int PEND_W = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     rs_addr,
    input  logic [ADDR_W-1:0]     rt_addr,
    output logic [DATA_W-1:0]     rs_data,
    output logic [DATA_W-1:0]     rt_data,
    output logic [DATA_W-1:0]     hi_data,
    output logic [DATA_W-1:0]     lo_data,
    input  logic                  rd_rs_en,
    input  logic                  rd_rt_en,
    input  logic                  rd_hilo_en,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    input  logic                  iss_hilo,
    input  logic                  wb_en,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  wb_hilo_en,
    input  logic [2*DATA_W-1:0]   wb_prod,
    output logic                  stall,
    output logic                  sb_err
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [DATA_W-1:0] gpr_reg  [DEPTH];
    logic [PEND_W-1:0] cnt_reg  [DEPTH];
    logic [PEND_W-1:0] cnt_next [DEPTH];
    logic [DATA_W-1:0] hi_reg, lo_reg;
    logic [PEND_W-1:0] cnt_hilo_reg, cnt_hilo_next;
    logic              sb_err_reg, sb_err_next;

    logic [DEPTH-1:0]  dec_vec, inc_vec, peff_vec, ovf_vec;
    logic              dec_hilo, inc_hilo, peff_hilo, ovf_hilo;
    logic              hazard, wb_err;

    // Per-register scoreboard counters; register 0 never tracks anything.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cnt
            if (gi == 0) begin : g_zero
                assign dec_vec[gi]  = 1'b0;
                assign inc_vec[gi]  = 1'b0;
                assign peff_vec[gi] = 1'b0;
                assign ovf_vec[gi]  = 1'b0;
                assign cnt_next[gi] = '0;
            end else begin : g_reg
                assign dec_vec[gi]  = wb_en && (wb_addr == ADDR_W'(gi)) && (cnt_reg[gi] != '0);
                assign inc_vec[gi]  = iss_en && !hazard && (iss_addr == ADDR_W'(gi));
                assign peff_vec[gi] = (cnt_reg[gi] - PEND_W'(dec_vec[gi])) != '0;
                assign ovf_vec[gi]  = inc_vec[gi] && !dec_vec[gi] && (cnt_reg[gi] == CNT_MAX);
                assign cnt_next[gi] = (inc_vec[gi] && !dec_vec[gi] && !ovf_vec[gi]) ? cnt_reg[gi] + CNT_ONE :
                                      (dec_vec[gi] && !inc_vec[gi])                 ? cnt_reg[gi] - CNT_ONE :
                                                                                       cnt_reg[gi];
            end
        end
    endgenerate

    assign dec_hilo  = wb_hilo_en && (cnt_hilo_reg != '0);
    assign inc_hilo  = iss_en && !hazard && iss_hilo;
    assign peff_hilo = (cnt_hilo_reg - PEND_W'(dec_hilo)) != '0;
    assign ovf_hilo  = inc_hilo && !dec_hilo && (cnt_hilo_reg == CNT_MAX);
    assign cnt_hilo_next = (inc_hilo && !dec_hilo && !ovf_hilo) ? cnt_hilo_reg + CNT_ONE :
                           (dec_hilo && !inc_hilo)              ? cnt_hilo_reg - CNT_ONE :
                                                                   cnt_hilo_reg;

    // A writeback landing this cycle is bypassed, so only the residual count stalls.
    assign hazard = (rd_rs_en && (rs_addr != '0) && peff_vec[rs_addr])
                 || (rd_rt_en && (rt_addr != '0) && peff_vec[rt_addr])
                 || (rd_hilo_en && peff_hilo)
                 || (iss_en && (iss_addr != '0) && (cnt_reg[iss_addr] == CNT_MAX) && !dec_vec[iss_addr])
                 || (iss_en && iss_hilo && (cnt_hilo_reg == CNT_MAX) && !dec_hilo);

    assign stall = hazard && !reset;

    assign wb_err = (wb_en && (wb_addr != '0) && (cnt_reg[wb_addr] == '0))
                 || (wb_hilo_en && (cnt_hilo_reg == '0));
    assign sb_err_next = sb_err_reg || wb_err || (|ovf_vec) || ovf_hilo;
    assign sb_err = sb_err_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                gpr_reg[i] <= '0;
                cnt_reg[i] <= '0;
            end
            hi_reg       <= '0;
            lo_reg       <= '0;
            cnt_hilo_reg <= '0;
            sb_err_reg   <= 1'b0;
        end else begin
            if (wb_en && (wb_addr != '0)) begin
                gpr_reg[wb_addr] <= wb_data;
            end
            if (wb_hilo_en) begin
                hi_reg <= wb_prod[2*DATA_W-1:DATA_W];
                lo_reg <= wb_prod[DATA_W-1:0];
            end
            for (int i = 0; i < DEPTH; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
            cnt_hilo_reg <= cnt_hilo_next;
            sb_err_reg   <= sb_err_next;
        end
    end

    always_comb begin
        rs_data = '0;
        rt_data = '0;
        hi_data = '0;
        lo_data = '0;
        if (!reset) begin
            if (rs_addr != '0) begin
                rs_data = (wb_en && (wb_addr == rs_addr)) ? wb_data : gpr_reg[rs_addr];
            end
            if (rt_addr != '0) begin
                rt_data = (wb_en && (wb_addr == rt_addr)) ? wb_data : gpr_reg[rt_addr];
            end
            hi_data = wb_hilo_en ? wb_prod[2*DATA_W-1:DATA_W] : hi_reg;
            lo_data = wb_hilo_en ? wb_prod[DATA_W-1:0]        : lo_reg;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed hazard/bypass scenarios followed by random
// traffic, all checked against an integer-count scoreboard model.
module tb_regfile_sb;
    localparam int PMAX = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  rs_addr, rt_addr, iss_addr, wb_addr;
    logic [31:0] rs_data, rt_data, hi_data, lo_data, wb_data;
    logic        rd_rs_en, rd_rt_en, rd_hilo_en, iss_en, iss_hilo;
    logic        wb_en, wb_hilo_en, stall, sb_err;
    logic [63:0] wb_prod;

    int passed = 0;
    int total  = 0;

    logic [31:0] m_gpr [32];
    int          m_cnt [32];
    logic [31:0] m_hi, m_lo;
    int          m_cnt_hilo;
    bit          m_err;

    always #5 clock = ~clock;

    regfile_sb dut (
        .clock(clock), .reset(reset),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .hi_data(hi_data), .lo_data(lo_data),
        .rd_rs_en(rd_rs_en), .rd_rt_en(rd_rt_en), .rd_hilo_en(rd_hilo_en),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_hilo(iss_hilo),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_hilo_en(wb_hilo_en), .wb_prod(wb_prod),
        .stall(stall), .sb_err(sb_err)
    );

    function automatic bit m_dec(logic [4:0] r);
        return wb_en && (r != 0) && (wb_addr == r) && (m_cnt[r] > 0);
    endfunction

    function automatic bit m_peff(logic [4:0] r);
        return (r != 0) && ((m_cnt[r] - int'(m_dec(r))) != 0);
    endfunction

    function automatic bit m_dec_hilo();
        return wb_hilo_en && (m_cnt_hilo > 0);
    endfunction

    function automatic bit m_stall();
        if (reset) return 1'b0;
        return (rd_rs_en && m_peff(rs_addr))
            || (rd_rt_en && m_peff(rt_addr))
            || (rd_hilo_en && ((m_cnt_hilo - int'(m_dec_hilo())) != 0))
            || (iss_en && (iss_addr != 0) && (m_cnt[iss_addr] == PMAX) && !m_dec(iss_addr))
            || (iss_en && iss_hilo && (m_cnt_hilo == PMAX) && !m_dec_hilo());
    endfunction

    function automatic logic [31:0] m_read(logic [4:0] a);
        if (reset || a == 0) return 32'h0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_gpr[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_gpr[i] = 32'h0;
            m_cnt[i] = 0;
        end
        m_hi = 32'h0;
        m_lo = 32'h0;
        m_cnt_hilo = 0;
        m_err = 1'b0;
    endtask

    task automatic m_update();
        bit s, d, dh;
        if (reset) begin
            m_reset();
            return;
        end
        s  = m_stall();
        d  = m_dec(wb_addr);
        dh = m_dec_hilo();
        if ((wb_en && wb_addr != 0 && m_cnt[wb_addr] == 0) || (wb_hilo_en && m_cnt_hilo == 0))
            m_err = 1'b1;
        if (wb_en && wb_addr != 0) m_gpr[wb_addr] = wb_data;
        if (wb_hilo_en) {m_hi, m_lo} = wb_prod;
        if (d)  m_cnt[wb_addr]--;
        if (dh) m_cnt_hilo--;
        if (iss_en && !s && iss_addr != 0) m_cnt[iss_addr]++;
        if (iss_en && !s && iss_hilo) m_cnt_hilo++;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle();
        rs_addr = 0; rt_addr = 0; rd_rs_en = 0; rd_rt_en = 0; rd_hilo_en = 0;
        iss_en = 0; iss_addr = 0; iss_hilo = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0; wb_hilo_en = 0; wb_prod = 0;
    endtask

    // Settle the inputs, then compare every output against the model.
    task automatic eval();
        #1;
        chk("rs_data", 64'(rs_data), 64'(m_read(rs_addr)));
        chk("rt_data", 64'(rt_data), 64'(m_read(rt_addr)));
        chk("hi_data", 64'(hi_data), reset ? 64'h0 : (wb_hilo_en ? 64'(wb_prod[63:32]) : 64'(m_hi)));
        chk("lo_data", 64'(lo_data), reset ? 64'h0 : (wb_hilo_en ? 64'(wb_prod[31:0]) : 64'(m_lo)));
        chk("stall", 64'(stall), 64'(m_stall()));
        chk("sb_err", 64'(sb_err), 64'(m_err));
    endtask

    task automatic tick();
        @(posedge clock);
        m_update();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clock);
        m_reset();
        #1;
        eval(); tick();

        // Bypass then storage read of r5
        reset = 1'b0;
        wb_en = 1; wb_addr = 5; wb_data = 32'hDEADBEEF; rs_addr = 5;
        eval(); chk("tp1_bypass", 64'(rs_data), 64'hDEADBEEF); tick();
        wb_en = 0;
        eval(); chk("tp1_stored", 64'(rs_data), 64'hDEADBEEF); tick();

        // Register 0 stays zero
        wb_en = 1; wb_addr = 0; wb_data = 32'h1234; rs_addr = 0;
        eval(); chk("tp2_r0_same", 64'(rs_data), 64'h0); tick();
        wb_en = 0;
        eval(); chk("tp2_r0_next", 64'(rs_data), 64'h0); tick();

        reset = 1'b1; idle(); eval(); tick();
        reset = 1'b0;

        // RAW on r7 resolved by its writeback
        iss_en = 1; iss_addr = 7;
        eval(); tick();
        idle(); rd_rs_en = 1; rs_addr = 7;
        eval(); chk("tp3_stall", 64'(stall), 64'h1); tick();
        eval(); tick();
        wb_en = 1; wb_addr = 7; wb_data = 32'h55;
        eval(); chk("tp3_release", 64'(stall), 64'h0); chk("tp3_bypass", 64'(rs_data), 64'h55); tick();

        // Counter saturation on r9
        idle(); iss_en = 1; iss_addr = 9;
        for (int k = 0; k < 3; k++) begin
            eval(); tick();
        end
        eval(); chk("tp4_full_stall", 64'(stall), 64'h1); tick();
        idle(); wb_en = 1; wb_addr = 9; wb_data = 32'h99;
        eval(); tick();
        eval(); tick();
        idle(); rd_rs_en = 1; rs_addr = 9;
        eval(); chk("tp4_still_pending", 64'(stall), 64'h1); tick();
        wb_en = 1; wb_addr = 9; wb_data = 32'h9A;
        eval(); chk("tp4_last_wb", 64'(stall), 64'h0); tick();

        // HI/LO hazard with concurrent GPR writeback
        idle(); iss_en = 1; iss_addr = 3; iss_hilo = 1;
        eval(); tick();
        idle(); rd_hilo_en = 1;
        eval(); chk("tp5_hilo_stall", 64'(stall), 64'h1); tick();
        wb_hilo_en = 1; wb_prod = 64'h00000001_FFFFFFFE;
        wb_en = 1; wb_addr = 3; wb_data = 32'hCAFE0003;
        eval();
        chk("tp5_release", 64'(stall), 64'h0);
        chk("tp5_hi", 64'(hi_data), 64'h1);
        chk("tp5_lo", 64'(lo_data), 64'hFFFFFFFE);
        tick();
        idle(); rs_addr = 3;
        eval(); chk("tp5_r3", 64'(rs_data), 64'hCAFE0003); chk("tp5_no_err", 64'(sb_err), 64'h0); tick();

        // Unexpected writeback sets sb_err; reset clears everything
        wb_en = 1; wb_addr = 4; wb_data = 32'h44;
        eval(); tick();
        idle(); rs_addr = 4;
        eval(); chk("tp6_err", 64'(sb_err), 64'h1); chk("tp6_r4", 64'(rs_data), 64'h44); tick();
        idle(); iss_en = 1; iss_addr = 4;
        eval(); tick();
        idle(); reset = 1'b1; rd_rs_en = 1; rs_addr = 4;
        eval(); chk("tp6_rst_rs", 64'(rs_data), 64'h0); chk("tp6_rst_stall", 64'(stall), 64'h0); tick();
        reset = 1'b0;
        eval();
        chk("tp6_post_stall", 64'(stall), 64'h0);
        chk("tp6_post_err", 64'(sb_err), 64'h0);
        chk("tp6_post_rs", 64'(rs_data), 64'h0);
        tick();

        // Random traffic on a narrow address window to provoke hazards
        for (int n = 0; n < 600; n++) begin
            reset      = ($urandom_range(0, 99) < 2);
            rs_addr    = 5'($urandom_range(0, 7));
            rt_addr    = 5'($urandom_range(0, 7));
            rd_rs_en   = 1'($urandom_range(0, 1));
            rd_rt_en   = 1'($urandom_range(0, 1));
            rd_hilo_en = ($urandom_range(0, 3) == 0);
            iss_en     = 1'($urandom_range(0, 1));
            iss_addr   = 5'($urandom_range(0, 7));
            iss_hilo   = ($urandom_range(0, 5) == 0);
            wb_en      = 1'($urandom_range(0, 1));
            wb_addr    = 5'($urandom_range(0, 7));
            wb_data    = $urandom;
            wb_hilo_en = ($urandom_range(0, 5) == 0);
            wb_prod    = {$urandom, $urandom};
            eval(); tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
